dma_bd_ram_mc: RTL and testbench

DMA_BD_RAM_MC -- requirements
Module: dma_bd_ram_mc

---
 rtl/dma_bd_pkg.sv | 34 +++
 rtl/dma_bd_ram_core.sv | 109 ++++++++++
 rtl/dma_bd_ram_mc.sv | 175 +++++++++++++++++
 tb/tb_dma_bd_ram_mc.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_bd_pkg.sv
// Shared definitions for the DMA buffer-descriptor RAM: error-injection codes,
// event-counter constants and the SECDED check-bit width.
package dma_bd_pkg;

   typedef enum logic [1:0] {
      ErrNone      = 2'b00,
      ErrSingle    = 2'b01,
      ErrDouble    = 2'b10,
      ErrDoubleAlt = 2'b11
   } err_inj_e;

   localparam int unsigned CntWidth = 8;
   localparam logic [CntWidth-1:0] CntMax = 8'd255;

   // Injected faults flip codeword positions 3 and 5, i.e. data bits 0 and 1.
   localparam int unsigned InjPosA = 3;
   localparam int unsigned InjPosB = 5;

   // Hamming bits for data_width plus one overall-parity bit.
   function automatic int unsigned ecc_check_width(input int unsigned data_width);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < data_width + r + 1) r++;
      return r + 1;
   endfunction

   function automatic logic [CntWidth-1:0] sat_count(input logic [CntWidth-1:0] cnt,
                                                     input logic evt, input logic clr);
      if (clr) return {{(CntWidth-1){1'b0}}, evt};
      if (evt && cnt != CntMax) return cnt + 1'b1;
      return cnt;
   endfunction

endpackage

// File: rtl/dma_bd_ram_core.sv
// Descriptor storage with SECDED encode on write and correct/detect on read.
// Check bits exist only when DMA_BD_RAM_ECC_EN is defined.
module dma_bd_ram_core
   import dma_bd_pkg::*;
#(
   parameter int DATA_WIDTH        = 32,
   parameter int NUM_INT_BDS_WIDTH = 4
) (
   input  logic                         clock,
   input  logic                         wr_en,
   input  logic [NUM_INT_BDS_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic [1:0]                   err_inj,
   input  logic [NUM_INT_BDS_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0]        rd_data,
   output logic                         rd_sb,
   output logic                         rd_db
);

   localparam int Depth = 2 ** NUM_INT_BDS_WIDTH;

`ifdef DMA_BD_RAM_ECC_EN
   localparam int CheckW = int'(ecc_check_width(DATA_WIDTH));
   localparam int HamW   = CheckW - 1;
   localparam int CodeW  = DATA_WIDTH + CheckW;

   logic [CodeW-1:0] mem [Depth];
   logic [CodeW-1:0] wr_code;
   logic [CodeW-1:0] rd_raw;
   logic [CodeW-1:0] rd_fixed;
   logic [HamW-1:0]  syndrome;
   logic             parity;

   // Codeword bit 0 is overall parity; power-of-two positions hold Hamming bits.
   function automatic logic [CodeW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
      logic [CodeW-1:0] cw;
      logic             p;
      int               k;
      cw = '0;
      k  = 0;
      for (int pos = 1; pos < CodeW; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            cw[pos] = d[k];
            k++;
         end
      end
      for (int i = 0; i < HamW; i++) begin
         p = 1'b0;
         for (int pos = 1; pos < CodeW; pos++) if (pos[i]) p ^= cw[pos];
         cw[1 << i] = p;
      end
      cw[0] = ^cw;
      return cw;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] extract(input logic [CodeW-1:0] cw);
      logic [DATA_WIDTH-1:0] d;
      int                    k;
      d = '0;
      k = 0;
      for (int pos = 1; pos < CodeW; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            d[k] = cw[pos];
            k++;
         end
      end
      return d;
   endfunction

   always_comb begin
      wr_code = encode(wr_data);
      if (err_inj != ErrNone) wr_code[InjPosA] = ~wr_code[InjPosA];
      if (err_inj[1])         wr_code[InjPosB] = ~wr_code[InjPosB];
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_code;
   end

   always_comb begin
      rd_raw   = mem[rd_addr];
      syndrome = '0;
      for (int pos = 1; pos < CodeW; pos++) if (rd_raw[pos]) syndrome ^= pos[HamW-1:0];
      parity   = ^rd_raw;
      rd_fixed = rd_raw;
      for (int pos = 1; pos < CodeW; pos++) begin
         if (parity && int'(syndrome) == pos) rd_fixed[pos] = ~rd_fixed[pos];
      end
      rd_sb   = parity;
      rd_db   = !parity && (syndrome != '0);
      // Uncorrectable words are returned exactly as stored.
      rd_data = extract(rd_db ? rd_raw : rd_fixed);
   end
`else
   logic [DATA_WIDTH-1:0] mem [Depth];
   logic                  unused_err_inj;

   assign unused_err_inj = ^err_inj;

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];
   assign rd_sb   = 1'b0;
   assign rd_db   = 1'b0;
`endif

endmodule

// File: rtl/dma_bd_ram_mc.sv
// Descriptor RAM wrapper: write-first forwarding, read pipeline, rdValid and
// ECC error bookkeeping (flags/counters/dbAddr live only with DMA_BD_RAM_ECC_EN).
module dma_bd_ram_mc
   import dma_bd_pkg::*;
#(
   parameter int DATA_WIDTH        = 32,
   parameter int NUM_INT_BDS_WIDTH = 4,
   parameter int RD_PIPELINE       = 1
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic                         wrEn,
   input  logic [NUM_INT_BDS_WIDTH-1:0] wrAddr,
   input  logic [DATA_WIDTH-1:0]        wrData,
   input  logic [1:0]                   errInj,
   input  logic                         rdEn,
   input  logic [NUM_INT_BDS_WIDTH-1:0] rdAddr,
   input  logic                         errClr,
   output logic [DATA_WIDTH-1:0]        rdData,
   output logic                         rdValid,
   output logic                         error_flag_sb_bd,
   output logic                         error_flag_db_bd,
   output logic [CntWidth-1:0]          sbCnt,
   output logic [CntWidth-1:0]          dbCnt,
   output logic [NUM_INT_BDS_WIDTH-1:0] dbAddr
);

   localparam int AW = NUM_INT_BDS_WIDTH;

   logic [DATA_WIDTH-1:0] mem_data;
   logic                  mem_sb;
   logic                  mem_db;
   logic                  fwd;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  rd_word_sb;
   logic                  rd_word_db;

   dma_bd_ram_core #(
      .DATA_WIDTH        (DATA_WIDTH),
      .NUM_INT_BDS_WIDTH (NUM_INT_BDS_WIDTH)
   ) u_core (
      .clock   (clock),
      .wr_en   (wrEn),
      .wr_addr (wrAddr),
      .wr_data (wrData),
      .err_inj (errInj),
      .rd_addr (rdAddr),
      .rd_data (mem_data),
      .rd_sb   (mem_sb),
      .rd_db   (mem_db)
   );

   // Forwarded words bypass storage, so they carry no ECC status.
   always_comb begin
      fwd        = wrEn && (wrAddr == rdAddr);
      rd_word    = fwd ? wrData : mem_data;
      rd_word_sb = !fwd && mem_sb;
      rd_word_db = !fwd && mem_db;
   end

   logic                  out_load;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_sb;
   logic                  out_db;
   logic [AW-1:0]         out_addr;

   if (RD_PIPELINE != 0) begin : g_pipe
      logic                  s1_valid_q;
      logic [DATA_WIDTH-1:0] s1_data_q;
      logic                  s1_sb_q;
      logic                  s1_db_q;
      logic [AW-1:0]         s1_addr_q;

      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_sb_q    <= 1'b0;
            s1_db_q    <= 1'b0;
            s1_addr_q  <= '0;
         end else begin
            s1_valid_q <= rdEn;
            if (rdEn) begin
               s1_data_q <= rd_word;
               s1_sb_q   <= rd_word_sb;
               s1_db_q   <= rd_word_db;
               s1_addr_q <= rdAddr;
            end
         end
      end

      assign out_load = s1_valid_q;
      assign out_data = s1_data_q;
      assign out_sb   = s1_sb_q;
      assign out_db   = s1_db_q;
      assign out_addr = s1_addr_q;
   end else begin : g_nopipe
      assign out_load = rdEn;
      assign out_data = rd_word;
      assign out_sb   = rd_word_sb;
      assign out_db   = rd_word_db;
      assign out_addr = rdAddr;
   end

   logic                  rd_valid_q;
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= out_load;
         if (out_load) rd_data_q <= out_data;
      end
   end

   assign rdValid = rd_valid_q;
   assign rdData  = rd_data_q;

`ifdef DMA_BD_RAM_ECC_EN
   logic                sb_evt;
   logic                db_evt;
   logic                sb_flag_q, sb_flag_d;
   logic                db_flag_q, db_flag_d;
   logic [CntWidth-1:0] sb_cnt_q, sb_cnt_d;
   logic [CntWidth-1:0] db_cnt_q, db_cnt_d;
   logic [AW-1:0]       db_addr_q, db_addr_d;

   // Events land on the same edge that raises rdValid for their read.
   always_comb begin
      sb_evt    = out_load && out_sb && !out_db;
      db_evt    = out_load && out_db;
      sb_flag_d = sb_evt || (sb_flag_q && !errClr);
      db_flag_d = db_evt || (db_flag_q && !errClr);
      sb_cnt_d  = sat_count(sb_cnt_q, sb_evt, errClr);
      db_cnt_d  = sat_count(db_cnt_q, db_evt, errClr);
      db_addr_d = db_addr_q;
      if (db_evt && !db_flag_q) db_addr_d = out_addr;
      else if (errClr)          db_addr_d = '0;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sb_flag_q <= 1'b0;
         db_flag_q <= 1'b0;
         sb_cnt_q  <= '0;
         db_cnt_q  <= '0;
         db_addr_q <= '0;
      end else begin
         sb_flag_q <= sb_flag_d;
         db_flag_q <= db_flag_d;
         sb_cnt_q  <= sb_cnt_d;
         db_cnt_q  <= db_cnt_d;
         db_addr_q <= db_addr_d;
      end
   end

   assign error_flag_sb_bd = sb_flag_q;
   assign error_flag_db_bd = db_flag_q;
   assign sbCnt            = sb_cnt_q;
   assign dbCnt            = db_cnt_q;
   assign dbAddr           = db_addr_q;
`else
   logic unused_ecc;

   assign unused_ecc       = ^{errClr, out_sb, out_db, out_addr};
   assign error_flag_sb_bd = 1'b0;
   assign error_flag_db_bd = 1'b0;
   assign sbCnt            = '0;
   assign dbCnt            = '0;
   assign dbAddr           = '0;
`endif

endmodule

// File: tb/tb_dma_bd_ram_mc.sv
// Bench for dma_bd_ram_mc: two instances (RD_PIPELINE 0 and 1) share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_dma_bd_ram_mc;

   typedef struct packed {
      int          due;
      logic [31:0] data;
      logic        sb;
      logic        db;
      logic [3:0]  addr;
   } rd_t;

   logic        clock = 1'b0;
   logic        resetn = 1'b1;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [1:0]  err_inj = '0;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_addr = '0;
   logic        err_clr = 1'b0;

   logic [31:0] rd_data [2];
   logic        rd_valid [2];
   logic        flag_sb [2];
   logic        flag_db [2];
   logic [7:0]  sb_cnt [2];
   logic [7:0]  db_cnt [2];
   logic [3:0]  db_addr [2];

   always #5 clock = ~clock;

   dma_bd_ram_mc #(.DATA_WIDTH(32), .NUM_INT_BDS_WIDTH(4), .RD_PIPELINE(0)) u_dut0 (
      .clock(clock), .resetn(resetn), .wrEn(wr_en), .wrAddr(wr_addr), .wrData(wr_data),
      .errInj(err_inj), .rdEn(rd_en), .rdAddr(rd_addr), .errClr(err_clr),
      .rdData(rd_data[0]), .rdValid(rd_valid[0]), .error_flag_sb_bd(flag_sb[0]),
      .error_flag_db_bd(flag_db[0]), .sbCnt(sb_cnt[0]), .dbCnt(db_cnt[0]),
      .dbAddr(db_addr[0])
   );

   dma_bd_ram_mc #(.DATA_WIDTH(32), .NUM_INT_BDS_WIDTH(4), .RD_PIPELINE(1)) u_dut1 (
      .clock(clock), .resetn(resetn), .wrEn(wr_en), .wrAddr(wr_addr), .wrData(wr_data),
      .errInj(err_inj), .rdEn(rd_en), .rdAddr(rd_addr), .errClr(err_clr),
      .rdData(rd_data[1]), .rdValid(rd_valid[1]), .error_flag_sb_bd(flag_sb[1]),
      .error_flag_db_bd(flag_db[1]), .sbCnt(sb_cnt[1]), .dbCnt(db_cnt[1]),
      .dbAddr(db_addr[1])
   );

   int n_checks = 0;
   int n_pass = 0;
   int edge_n = 0;

   logic [31:0] mem_m [16];
`ifdef DMA_BD_RAM_ECC_EN
   logic [1:0]  kind_m [16];
`endif
   rd_t         q0[$];
   rd_t         q1[$];

   bit          exp_valid [2];
   logic [31:0] exp_data [2];
   bit          sbf [2];
   bit          dbf [2];
   int          sbc [2];
   int          dbc [2];
   logic [3:0]  dba [2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic compare_outputs();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("pipe%0d rdValid", k), 64'(rd_valid[k]), 64'(exp_valid[k]));
         check($sformatf("pipe%0d rdData", k), 64'(rd_data[k]), 64'(exp_data[k]));
         check($sformatf("pipe%0d sb flag", k), 64'(flag_sb[k]), 64'(sbf[k]));
         check($sformatf("pipe%0d db flag", k), 64'(flag_db[k]), 64'(dbf[k]));
         check($sformatf("pipe%0d sbCnt", k), 64'(sb_cnt[k]), 64'(sbc[k]));
         check($sformatf("pipe%0d dbCnt", k), 64'(db_cnt[k]), 64'(dbc[k]));
         check($sformatf("pipe%0d dbAddr", k), 64'(db_addr[k]), 64'(dba[k]));
      end
   endtask

   // Apply one completed read (or none) and the current errClr to instance k's model.
   task automatic retire(input int k, input bit v, input rd_t r);
      bit sev, dev;
      exp_valid[k] = v;
      if (v) exp_data[k] = r.data;
      sev = v && r.sb && !r.db;
      dev = v && r.db;
`ifdef DMA_BD_RAM_ECC_EN
      if (dev && !dbf[k]) dba[k] = r.addr;
      else if (err_clr)   dba[k] = '0;
      sbf[k] = sev || (sbf[k] && !err_clr);
      dbf[k] = dev || (dbf[k] && !err_clr);
      if (err_clr) begin
         sbc[k] = sev ? 1 : 0;
         dbc[k] = dev ? 1 : 0;
      end else begin
         if (sev && sbc[k] < 255) sbc[k]++;
         if (dev && dbc[k] < 255) dbc[k]++;
      end
`else
      if (sev || dev) $display("FAIL model: ECC event without ECC build");
`endif
   endtask

   task automatic tick();
      rd_t r, r0, r1;
      bit  v0, v1;
      int  e;
      e = edge_n + 1;
      r = '0;
      r0 = '0;
      r1 = '0;
      if (rd_en) begin
         r.addr = rd_addr;
         r.sb   = 1'b0;
         r.db   = 1'b0;
         if (wr_en && wr_addr == rd_addr) r.data = wr_data;
         else begin
            r.data = mem_m[rd_addr];
`ifdef DMA_BD_RAM_ECC_EN
            if (kind_m[rd_addr] == 2'b01) r.sb = 1'b1;
            else if (kind_m[rd_addr] != 2'b00) begin
               r.db   = 1'b1;
               r.data = r.data ^ 32'h3;
            end
`endif
         end
         r.due = e;
         q0.push_back(r);
         r.due = e + 1;
         q1.push_back(r);
      end
      if (wr_en) begin
         mem_m[wr_addr] = wr_data;
`ifdef DMA_BD_RAM_ECC_EN
         kind_m[wr_addr] = err_inj;
`endif
      end
      v0 = (q0.size() > 0) && (q0[0].due == e);
      if (v0) r0 = q0.pop_front();
      v1 = (q1.size() > 0) && (q1[0].due == e);
      if (v1) r1 = q1.pop_front();
      retire(0, v0, r0);
      retire(1, v1, r1);
      edge_n = e;
      @(posedge clock);
      #1;
      compare_outputs();
   endtask

   task automatic idle(input int n);
      wr_en = 1'b0;
      rd_en = 1'b0;
      err_clr = 1'b0;
      err_inj = 2'b00;
      repeat (n) tick();
   endtask

   task automatic do_reset(input int n);
      wr_en = 1'b0;
      rd_en = 1'b0;
      err_clr = 1'b0;
      err_inj = 2'b00;
      resetn = 1'b0;
      #1;
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
         exp_valid[k] = 1'b0;
         exp_data[k]  = '0;
         sbf[k] = 1'b0;
         dbf[k] = 1'b0;
         sbc[k] = 0;
         dbc[k] = 0;
         dba[k] = '0;
      end
      compare_outputs();
      repeat (n) begin
         @(posedge clock);
         #1;
         compare_outputs();
      end
      resetn = 1'b1;
   endtask

   initial begin
      #2;
      do_reset(3);

      // Initialise every location so no unwritten word is ever read.
      for (int a = 0; a < 16; a++) begin
         wr_en = 1'b1;
         wr_addr = 4'(a);
         wr_data = (a == 5) ? 32'h0 : $urandom;
         tick();
      end
      idle(1);

      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hA5A5_0001;
      tick();
      idle(1);
      rd_en = 1'b1; rd_addr = 4'd3;
      tick();
      idle(3);

      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h1234_5678;
      rd_en = 1'b1; rd_addr = 4'd5;
      tick();
      idle(3);

      for (int a = 0; a < 16; a++) begin
         rd_en = 1'b1;
         rd_addr = 4'(a);
         tick();
      end
      idle(3);

`ifdef DMA_BD_RAM_ECC_EN
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hCAFE_0002; err_inj = 2'b01;
      tick();
      idle(1);
      rd_en = 1'b1; rd_addr = 4'd2;
      tick();
      idle(3);
      err_clr = 1'b1;
      tick();
      idle(2);

      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h0BAD_0007; err_inj = 2'b10;
      tick();
      idle(1);
      rd_en = 1'b1; rd_addr = 4'd7;
      repeat (2) tick();
      idle(3);
      rd_en = 1'b1; rd_addr = 4'd7;
      repeat (300) tick();
      idle(3);
      err_clr = 1'b1;
      tick();
      idle(2);
`endif

      for (int i = 0; i < 800; i++) begin
         wr_en   = $urandom_range(0, 1) == 1;
         wr_addr = 4'($urandom_range(0, 15));
         wr_data = $urandom;
         err_inj = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rd_en   = $urandom_range(0, 3) != 0;
         rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
         err_clr = $urandom_range(0, 31) == 0;
         tick();
      end
      idle(3);

      rd_en = 1'b1; rd_addr = 4'd1;
      tick();
      do_reset(3);
      idle(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
